// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate bank sweep sequencer.
// GATE_SWEEP_ERRCNT_EN adds a mismatch bit counter to the top.
package gate_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam int GATE_AND  = 0;
   localparam int GATE_OR   = 1;
   localparam int GATE_NOTA = 2;
   localparam int GATE_NOTB = 3;
   localparam int GATE_NAND = 4;
   localparam int GATE_NOR  = 5;
   localparam int GATE_XOR  = 6;
   localparam int GATE_XNOR = 7;

   localparam int NUM_VECS = 4;
   localparam logic [1:0] LAST_VEC = 2'(NUM_VECS - 1);

   function automatic logic [5:0] popcount8(input logic [7:0] v);
      logic [5:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         s = s + {5'd0, v[i]};
      end
      return s;
   endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Expected outputs of the two-input gate bank for one (a,b) vector.
// Purely combinational; also usable as a reference elsewhere.
module gate_golden_model
   import gate_sweep_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [7:0] expected
);

   always_comb begin
      expected            = '0;
      expected[GATE_AND]  = a & b;
      expected[GATE_OR]   = a | b;
      expected[GATE_NOTA] = ~a;
      expected[GATE_NOTB] = ~b;
      expected[GATE_NAND] = ~(a & b);
      expected[GATE_NOR]  = ~(a | b);
      expected[GATE_XOR]  = a ^ b;
      expected[GATE_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps the gate bank through 00,01,10,11 and checks every output.
// GATE_SWEEP_ERRCNT_EN adds the err_count mismatch bit counter port.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic       gate_a,
   output logic       gate_b,
   input  logic [7:0] gate_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_mask,
   output logic [1:0] vec_idx
`ifdef GATE_SWEEP_ERRCNT_EN
   ,
   output logic [5:0] err_count
`endif
);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_hold_chk
      $error("HOLD_CYCLES must be in 1..255");
   end

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state;
   logic [7:0] hold_cnt;
   logic [7:0] golden;
   logic [7:0] diff;

   gate_golden_model u_golden (
      .a        (vec_idx[1]),
      .b        (vec_idx[0]),
      .expected (golden)
   );

   assign diff   = gate_out ^ golden;
   assign gate_a = vec_idx[1];
   assign gate_b = vec_idx[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         vec_idx   <= '0;
         hold_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= '0;
`ifdef GATE_SWEEP_ERRCNT_EN
         err_count <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  state     <= ST_APPLY;
                  vec_idx   <= '0;
                  hold_cnt  <= '0;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  fail_mask <= '0;
`ifdef GATE_SWEEP_ERRCNT_EN
                  err_count <= '0;
`endif
               end
            end
            ST_APPLY: begin
               if (abort) begin
                  state    <= ST_IDLE;
                  vec_idx  <= '0;
                  hold_cnt <= '0;
                  busy     <= 1'b0;
                  pass     <= 1'b0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= ST_SAMPLE;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            ST_SAMPLE: begin
               // abort beats the sample update
               if (abort) begin
                  state    <= ST_IDLE;
                  vec_idx  <= '0;
                  hold_cnt <= '0;
                  busy     <= 1'b0;
                  pass     <= 1'b0;
               end else begin
                  fail_mask <= fail_mask | diff;
`ifdef GATE_SWEEP_ERRCNT_EN
                  err_count <= err_count + popcount8(diff);
`endif
                  if (vec_idx == LAST_VEC) begin
                     state   <= ST_DONE;
                     vec_idx <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     pass    <= ((fail_mask | diff) == 8'h00);
                  end else begin
                     state   <= ST_APPLY;
                     vec_idx <= vec_idx + 2'd1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized scoreboard bench for gate_sweep_ctrl with a faulty-bank model.
// Checks err_count only when GATE_SWEEP_ERRCNT_EN is defined.
module tb_gate_sweep_ctrl;

   localparam int H   = 4;
   localparam int LAT = 4 * (H + 1);

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic       gate_a, gate_b;
   logic [7:0] gate_out;
   logic       busy, done, pass;
   logic [7:0] fail_mask;
   logic [1:0] vec_idx;
   logic [5:0] err_count;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0][7:0] fm;
      logic [4:0][5:0] ec;
   } exp_t;

   exp_t       q[$];
   exp_t       cur;
   exp_t       me;
   logic [7:0] stuck, inv;
   logic       act_on, mon_en;
   int         act_k;
   logic [7:0] hold_fm;
   logic       hold_pass;
   logic [5:0] hold_err;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         mt, mn;

   function automatic logic [7:0] truth(input logic a, input logic b);
      logic [7:0] r;
      r[0] = a & b;
      r[1] = a | b;
      r[2] = !a;
      r[3] = !b;
      r[4] = !(a & b);
      r[5] = !(a | b);
      r[6] = a ^ b;
      r[7] = !(a ^ b);
      return r;
   endfunction

   // bank: true gate outputs, with stuck-at-0 bits and inverted bits
   assign gate_out = (truth(gate_a, gate_b) & ~stuck) ^ inv;

   function automatic exp_t model(input logic [7:0] s, input logic [7:0] v);
      exp_t       e;
      logic       a, b;
      logic [7:0] t, d;
      e = '0;
      for (int n = 0; n < 4; n++) begin
         a = (n >= 2);
         b = (n % 2 == 1);
         t = truth(a, b);
         d = t ^ ((t & ~s) ^ v);
         e.fm[n+1] = e.fm[n] | d;
         e.ec[n+1] = e.ec[n] + 6'($countones(d));
      end
      return e;
   endfunction

   gate_sweep_ctrl #(.HOLD_CYCLES(H)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .gate_a    (gate_a),
      .gate_b    (gate_b),
      .gate_out  (gate_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_mask (fail_mask),
      .vec_idx   (vec_idx)
`ifdef GATE_SWEEP_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

`ifndef GATE_SWEEP_ERRCNT_EN
   assign err_count = '0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                  nm, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (act_on) begin
            mt = cyc - act_k;
            if (mt < LAT) begin
               mn = mt / (H + 1);
               chk("busy_run", {31'd0, busy}, 1);
               chk("done_early", {31'd0, done}, 0);
               chk("vec_idx", {30'd0, vec_idx}, mn);
               chk("gate_ab", {30'd0, gate_a, gate_b}, mn);
               chk("fm_partial", {24'd0, fail_mask}, {24'd0, cur.fm[mn]});
               chk("pass_run", {31'd0, pass}, 0);
`ifdef GATE_SWEEP_ERRCNT_EN
               chk("err_partial", {26'd0, err_count}, {26'd0, cur.ec[mn]});
`endif
            end else begin
               chk("done", {31'd0, done}, 1);
               chk("busy_done", {31'd0, busy}, 0);
               chk("gate_done", {30'd0, gate_a, gate_b}, 0);
               chk("vec_done", {30'd0, vec_idx}, 0);
               if (q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL sb_empty cyc=%0d actual=done required=none",
                           cyc);
               end else begin
                  me = q.pop_front();
                  chk("fail_mask", {24'd0, fail_mask}, {24'd0, me.fm[4]});
                  chk("pass", {31'd0, pass}, {31'd0, me.fm[4] == 8'h00});
`ifdef GATE_SWEEP_ERRCNT_EN
                  chk("err_count", {26'd0, err_count}, {26'd0, me.ec[4]});
`endif
               end
            end
         end else begin
            chk("busy_idle", {31'd0, busy}, 0);
            chk("done_idle", {31'd0, done}, 0);
            chk("gate_idle", {30'd0, gate_a, gate_b}, 0);
            chk("vec_idle", {30'd0, vec_idx}, 0);
            chk("fm_hold", {24'd0, fail_mask}, {24'd0, hold_fm});
            chk("pass_hold", {31'd0, pass}, {31'd0, hold_pass});
`ifdef GATE_SWEEP_ERRCNT_EN
            chk("err_hold", {26'd0, err_count}, {26'd0, hold_err});
`endif
         end
      end
   end

   task automatic run_sweep(input logic [7:0] s, input logic [7:0] v,
                            input int abort_t, input int rst_t,
                            input int restart_t);
      int  t;
      bit  fin;
      stuck = s;
      inv   = v;
      cur   = model(s, v);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      act_k  = cyc;
      act_on = 1'b1;
      if (abort_t < 0 && rst_t < 0) q.push_back(cur);
      fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         t = cyc - act_k;
         if (t == restart_t) start = 1'b1;
         if (t == abort_t) abort = 1'b1;
         if (t == rst_t) rst = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         abort = 1'b0;
         rst   = 1'b0;
         if (t == rst_t) begin
            act_on    = 1'b0;
            hold_fm   = '0;
            hold_pass = 1'b0;
            hold_err  = '0;
            fin       = 1'b1;
         end else if (t == abort_t) begin
            act_on    = 1'b0;
            hold_fm   = cur.fm[t/(H+1)];
            hold_pass = 1'b0;
            hold_err  = cur.ec[t/(H+1)];
            fin       = 1'b1;
         end else if (t >= LAT) begin
            act_on    = 1'b0;
            hold_fm   = cur.fm[4];
            hold_pass = (cur.fm[4] == 8'h00);
            hold_err  = cur.ec[4];
            fin       = 1'b1;
         end
      end
   endtask

   task automatic idle_abort();
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s, v;
      int         ab, rs;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      stuck     = '0;
      inv       = '0;
      act_on    = 1'b0;
      mon_en    = 1'b0;
      act_k     = 0;
      hold_fm   = '0;
      hold_pass = 1'b0;
      hold_err  = '0;
      cur       = model(8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_sweep(8'h00, 8'h00, -1, -1, -1);
      run_sweep(8'h40, 8'h00, -1, -1, -1);
      run_sweep(8'h00, 8'hFF, -1, -1, -1);
      run_sweep(8'h01, 8'h10, 2 * (H + 1) + 1, -1, -1);
      idle_abort();
      run_sweep(8'h00, 8'h00, -1, -1, 7);
      run_sweep(8'h08, 8'h00, -1, -1, LAT);
      run_sweep(8'h22, 8'h00, -1, 9, -1);
      run_sweep(8'h00, 8'h00, -1, -1, -1);
      run_sweep(8'h80, 8'h04, 2 * (H + 1) + H, -1, -1);
      idle_abort();

      for (int i = 0; i < 14; i++) begin
         s  = 8'($urandom & $urandom & $urandom);
         v  = 8'($urandom & $urandom & $urandom);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
         rs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LAT)) : -1;
         if (ab >= 0) rs = -1;
         run_sweep(s, v, ab, rs,
                   ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, LAT)) : -1);
         if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
      end

      repeat (4) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL sb_leftover actual=%0d required=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-checking sequencer for the two-input gate bank `tt_um_digital_gates`. On `start` it drives the bank's `a`/`b` inputs through all four combinations and holds each for a programmable settle time. It then samples the eight gate outputs and compares them against an internal golden model. It reports per-gate mismatches and an overall pass/fail with a start/busy/done handshake, replacing the hand-checked `$monitor` truth-table dump.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles each vector is applied before sampling; legal range 1..255; 0 is an elaboration error.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `abort`  in  1  cancel a running sweep.
- `gate_a`  out  1  drives bank input `a`.
- `gate_b`  out  1  drives bank input `b`.
- `gate_out`  in  8  bank outputs: [0] and, [1] or, [2] not_a, [3] not_b, [4] nand, [5] nor, [6] xor, [7] xnor.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  1 when the last completed sweep had `fail_mask==0`; held until the next accepted start.
- `fail_mask`  out  8  sticky per-gate mismatch flags, same bit order as `gate_out`.
- `vec_idx`  out  2  current vector; `gate_a=vec_idx[1]`, `gate_b=vec_idx[0]`.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE: `gate_a`/`gate_b` driven 0, `busy=0`.
  - `start=1` and `abort=0` -> APPLY with `vec_idx=0`, `hold_cnt=0`.
  - On acceptance, `fail_mask` and `pass` clear to 0.
- APPLY: drives the vector for exactly `HOLD_CYCLES` cycles, then -> SAMPLE.
- SAMPLE: one cycle.
  - `fail_mask |= gate_out ^ golden(vec_idx)`.
  - If `vec_idx==3` -> DONE; otherwise `vec_idx+1` -> APPLY.
- DONE: one cycle.
  - `done=1`, `busy=0`, `pass=(fail_mask==0)`.
  - `vec_idx` returns to 0; the bank inputs return to 0.
  - -> IDLE.
- Vector order is fixed: 00, 01, 10, 11. No wrap; a sweep ends after vector 3.
- Golden model per vector (a,b): `{~(a^b), a^b, ~(a|b), ~(a&b), ~b, ~a, a|b, a&b}`.
- `start` while busy (APPLY, SAMPLE or DONE) is ignored and not queued.
- `abort` in APPLY or SAMPLE:
  - -> IDLE next cycle; no `done` pulse.
  - `pass` forced 0; `fail_mask` keeps its partial value.
  - If `abort` and a SAMPLE update occur together, abort wins and no update is made.
- `abort` in IDLE: no effect; it also blocks a simultaneous `start`.
- `rst` at any time, including mid-sweep: next cycle is IDLE with all outputs at reset value.
- Reset values: `gate_a=0`, `gate_b=0`, `busy=0`, `done=0`, `pass=0`, `fail_mask=0`, `vec_idx=0`, `err_count=0`.

## Timing
- All outputs are registered.
- `start` is accepted at edge k.
  - `busy=1` and vector 0 are on the pins from cycle k+1.
  - Vector n is applied in cycles k+1+n·(H+1) .. k+H+n·(H+1), where H = `HOLD_CYCLES`.
  - Vector n is sampled in cycle k+(n+1)·(H+1).
- `done` is high in cycle k+4·(H+1)+1. Start-to-done latency = 4·(H+1)+1 cycles (21 for H=4).
- The bank is combinational, so H=1 is sufficient. Larger H models settle/debug time.
- A new `start` is accepted the cycle after `done`.

## Configuration
- `GATE_SWEEP_ERRCNT_EN` defined:
  - Adds port `err_count`  out  6: total mismatching bits across the sweep.
  - Each SAMPLE adds `popcount(gate_out ^ golden)`; the maximum is 32, so no saturation is needed.
  - Cleared on accepted start; held after `done` or abort.
- `GATE_SWEEP_ERRCNT_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- `gate_sweep_pkg` holds:
  - the state enum;
  - localparams for the `gate_out` bit indices;
  - the vector count (4).
- Sub-module `gate_golden_model`: combinational, (a,b) -> 8-bit expected vector. It is reusable by the testbench scoreboard.

## Test plan
- Good bank, H=4, pulse `start`:
  - `gate_a`/`gate_b` sequence 00,01,10,11, each for 4 cycles;
  - `done` exactly 21 cycles after start;
  - `pass=1`, `fail_mask=8'h00`, `err_count=0`.
- Bank model with xor stuck-at-0 -> `fail_mask=8'h40`, `pass=0`, `err_count=2`.
- All outputs inverted -> `fail_mask=8'hFF`, `err_count=32`, `pass=0`.
- `abort` asserted during APPLY of vector 2:
  - IDLE next cycle, no `done`, `pass=0`;
  - `fail_mask` reflects vectors 0–1 only.
- `start` re-pulsed while busy -> ignored; a single `done` at cycle 21.
- `rst` at cycle 10 of a sweep -> all outputs at reset values next cycle; a following `start` completes normally. With H=1, `done` comes 9 cycles after start.
